seq_slice_adder: RTL

Parametrised multi-cycle adder/subtractor, successor to the 4-bit combinational ripple-carry adder. It splits a WIDTH-bit carry chain into SLICE-bit segments and resolves one segment per clock, LSB first. Each segment carries over a registered carry, so the critical path stays one SLICE-bit adder. The block sits in the datapath as a start/done arithmetic unit, with add/sub mode and signed-overflow detection that the 4-bit adder lacks.

---
 rtl/seq_slice_adder_if.sv | 26 ++
 rtl/seq_slice_adder.sv | 115 +++++++++++
 2 files changed

// File: rtl/seq_slice_adder_if.sv
// Start/done handshake and operand/result bus of the sliced adder.
// master drives requests, slave (the adder) returns results.
interface seq_slice_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, sub, a, b, c_in,
    input  busy, done, sum, c_out, ovf
  );

  modport slave (
    input  start, sub, a, b, c_in,
    output busy, done, sum, c_out, ovf
  );
endinterface

// File: rtl/seq_slice_adder.sv
// Multi-cycle add/sub: resolves one SLICE-bit segment of the carry chain per
// clock, LSB first, with a registered carry between segments.

module seq_slice_unit #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co,
  output logic             cm
);
  logic [SLICE:0] t;

  assign t  = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};
  assign s  = t[SLICE-1:0];
  assign co = t[SLICE];
  // Carry into the slice MSB, recovered from the sum bit; feeds signed overflow.
  assign cm = s[SLICE-1] ^ a[SLICE-1] ^ b[SLICE-1];
endmodule

module seq_slice_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  seq_slice_adder_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a, op_b, work, work_next;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             last;
  logic [SLICE-1:0] sl_s;
  logic             sl_co, sl_cm;

  logic             busy_q, done_q, c_out_q, ovf_q;
  logic [WIDTH-1:0] sum_q;

  assign last = (idx == IW'(NSLICE - 1));

  seq_slice_unit #(.SLICE(SLICE)) u_slice (
    .a  (op_a[idx*SLICE +: SLICE]),
    .b  (op_b[idx*SLICE +: SLICE]),
    .ci (carry),
    .s  (sl_s),
    .co (sl_co),
    .cm (sl_cm)
  );

  always_comb begin
    work_next                      = work;
    work_next[idx*SLICE +: SLICE]  = sl_s;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      work    <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            // Subtract is a + ~b + 1; c_in only matters for add.
            op_a   <= bus.a;
            op_b   <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.sub | bus.c_in;
            idx    <= '0;
            state  <= RUN;
            busy_q <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          work  <= work_next;
          carry <= sl_co;
          idx   <= idx + 1'b1;
          if (last) begin
            state   <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= work_next;
            c_out_q <= sl_co;
            ovf_q   <= sl_cm ^ sl_co;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
  assign bus.ovf   = ovf_q;
endmodule
